// File: rtl/avalon_wb_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : avalon_wb_bridge_if
//  Brief    : Avalon-MM slave side and Wishbone classic master side bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface avalon_wb_bridge_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0]   avs_address;
   logic                avs_chipselect;
   logic                avs_read;
   logic                avs_write;
   logic [DATA_W/8-1:0] avs_byteenable;
   logic [DATA_W-1:0]   avs_writedata;
   logic [DATA_W-1:0]   avs_readdata;
   logic                avs_waitrequest;
   logic [ADDR_W-1:0]   wbm_adr_o;
   logic [DATA_W-1:0]   wbm_dat_o;
   logic [DATA_W-1:0]   wbm_dat_i;
   logic [DATA_W/8-1:0] wbm_sel_o;
   logic                wbm_cyc_o;
   logic                wbm_stb_o;
   logic                wbm_we_o;
   logic                wbm_ack_i;

   // Bridge view: Avalon slave facing the fabric, Wishbone master facing the peripheral.
   modport slave (
      input  avs_address, avs_chipselect, avs_read, avs_write,
      input  avs_byteenable, avs_writedata,
      output avs_readdata, avs_waitrequest,
      output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
      input  wbm_dat_i, wbm_ack_i
   );

   // Environment view: Avalon master plus Wishbone slave.
   modport master (
      output avs_address, avs_chipselect, avs_read, avs_write,
      output avs_byteenable, avs_writedata,
      input  avs_readdata, avs_waitrequest,
      input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
      output wbm_dat_i, wbm_ack_i
   );
endinterface
`default_nettype wire

// File: rtl/avalon_wb_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : avalon_wb_bridge
//  Brief    : Avalon-MM slave to Wishbone classic master bridge, IDLE/BUS/DONE
//             transfer FSM. Optional bus watchdog: AWB_BRIDGE_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module avalon_wb_bridge #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic              csi_clk,
   input  logic              rsi_reset,
   avalon_wb_bridge_if.slave bus,
   output logic              timeout_o,
   output logic [7:0]        timeout_cnt_o
);
   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic              start;
   logic              ack;
   logic              expire;
   logic [ADDR_W-1:0] adr;
   logic [DATA_W-1:0] wdat;
   logic [DATA_W-1:0] rdat;
   logic [BE_W-1:0]   sel;
   logic              we;

   assign start = bus.avs_chipselect & (bus.avs_read | bus.avs_write);
   assign ack   = (state == BUS) & bus.wbm_ack_i;

   always_ff @(posedge csi_clk) begin
      if (rsi_reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = BUS;
         BUS:     if (ack || expire) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request fields are latched once at launch and held for the whole cycle.
   always_ff @(posedge csi_clk) begin
      if (rsi_reset) begin
         adr  <= '0;
         wdat <= '0;
         sel  <= '0;
         we   <= 1'b0;
         rdat <= '0;
      end else begin
         if (state == IDLE && start) begin
            adr  <= bus.avs_address;
            wdat <= bus.avs_writedata;
            sel  <= bus.avs_byteenable;
            we   <= bus.avs_write & ~bus.avs_read;
         end
         if (ack && !we) begin
            rdat <= bus.wbm_dat_i;
         end else if (expire && !we) begin
            rdat <= '1;
         end
      end
   end

   assign bus.wbm_adr_o       = adr;
   assign bus.wbm_dat_o       = wdat;
   assign bus.wbm_sel_o       = sel;
   assign bus.wbm_cyc_o       = (state == BUS);
   assign bus.wbm_stb_o       = (state == BUS);
   assign bus.wbm_we_o        = (state == BUS) & we;
   assign bus.avs_readdata    = rdat;
   assign bus.avs_waitrequest = (state != DONE);

`ifdef AWB_BRIDGE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

   logic [CNT_W-1:0] tmo_cnt;

   // A same-cycle ack takes priority over expiry.
   assign expire = (state == BUS) && !bus.wbm_ack_i &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge csi_clk) begin
      if (rsi_reset) begin
         tmo_cnt       <= '0;
         timeout_o     <= 1'b0;
         timeout_cnt_o <= '0;
      end else begin
         timeout_o <= expire;
         if (state == IDLE && start) begin
            tmo_cnt <= '0;
         end else if (state == BUS && !bus.wbm_ack_i) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
         end
         if (expire && timeout_cnt_o != 8'hFF) begin
            timeout_cnt_o <= timeout_cnt_o + 8'd1;
         end
      end
   end
`else
   logic unused_timeout_cfg;

   assign expire             = 1'b0;
   assign timeout_o          = 1'b0;
   assign timeout_cnt_o      = 8'd0;
   assign unused_timeout_cfg = (TIMEOUT_CYC > 1);
`endif

endmodule
`default_nettype wire

// File: doc/avalon_wb_bridge.md
# avalon_wb_bridge

Parametrised Avalon-MM slave to Wishbone classic master bridge, successor to the fixed 8-bit glue that exposes Wishbone peripherals (e.g. the CAN core) to the Nios II Qsys fabric. It replaces the direct signal wiring with a registered transfer FSM, correct Avalon waitrequest semantics, configurable data and address widths with byte enables, and an optional bus-timeout watchdog. It sits between the Qsys interconnect and a single Wishbone slave in the same clock domain.

## Interface
Parameters:
- DATA_W, 8, data width in bits; multiple of 8 (8/16/32).
- ADDR_W, 8, address width in bits.
- TIMEOUT_CYC, 256, cycles in BUS before abort (>= 2); used only with the timeout feature.

Ports:
- csi_clk  in  1  bridge clock; all logic on rising edge.
- rsi_reset  in  1  reset; synchronous, active-high.
- avs_address  in  ADDR_W  word address.
- avs_chipselect  in  1  slave select.
- avs_read  in  1  read request.
- avs_write  in  1  write request.
- avs_byteenable  in  DATA_W/8  byte lanes.
- avs_writedata  in  DATA_W  write data.
- avs_readdata  out  DATA_W  read data, registered.
- avs_waitrequest  out  1  high = master must hold request.
- wbm_adr_o  out  ADDR_W  Wishbone address.
- wbm_dat_o  out  DATA_W  Wishbone write data.
- wbm_dat_i  in  DATA_W  Wishbone read data.
- wbm_sel_o  out  DATA_W/8  byte selects.
- wbm_cyc_o  out  1  cycle.
- wbm_stb_o  out  1  strobe.
- wbm_we_o  out  1  write enable.
- wbm_ack_i  in  1  slave acknowledge.
- timeout_o  out  1  one-cycle pulse on aborted transfer.
- timeout_cnt_o  out  8  saturating count of aborted transfers.

## Operation
- FSM states: IDLE, BUS, DONE. Reset -> IDLE.
- IDLE: if avs_chipselect & (avs_read | avs_write): latch address, writedata, byteenable, we = avs_write & ~avs_read (read wins if both); assert cyc/stb; -> BUS. Otherwise stay.
- BUS: cyc/stb/we/adr/dat/sel held constant. On wbm_ack_i: capture wbm_dat_i into avs_readdata (reads only; writes leave it unchanged), drop cyc/stb, -> DONE.
- DONE: avs_waitrequest low for exactly this one cycle; -> IDLE.
- avs_waitrequest is high in IDLE and BUS, low only in DONE.
- wbm_ack_i outside BUS is ignored.
- Request withdrawn while in BUS (protocol violation): the Wishbone cycle still completes normally.
- Reset values: avs_readdata 0, avs_waitrequest 1, wbm_cyc_o/stb_o/we_o 0, wbm_adr_o/dat_o/sel_o 0, timeout_o 0, timeout_cnt_o 0.
- Reset asserted mid-transfer: next edge forces IDLE and all reset values; the pending Avalon request is dropped.

## Timing
- Request sampled at edge N (IDLE); cyc/stb high from edge N+1; ack sampled at edge N+1+k (k >= 0 wait states); waitrequest low in the cycle after ack; minimum 3 cycles per transfer.
- Back-to-back: a new request may launch from the IDLE cycle immediately following DONE.
- Timeout counter is ceil(log2(TIMEOUT_CYC))+1 bits wide, cleared on entry to BUS, increments each BUS cycle without ack.

## Configuration
- Macro AWB_BRIDGE_TIMEOUT_EN.
- Defined: when the counter reaches TIMEOUT_CYC-1 in BUS without ack, drop cyc/stb, -> DONE, avs_readdata = all ones (reads), timeout_o pulses high during DONE, timeout_cnt_o increments, saturating at 255. Ack in the same cycle as expiry: ack wins, no timeout.
- Undefined: counter absent, BUS waits indefinitely; timeout_o and timeout_cnt_o tied 0.

## Test plan
- Reset, then DATA_W=8 write addr 0x10 data 0xA5, slave acks 0 wait states -> wbm_adr_o=0x10, wbm_dat_o=0xA5, we=1 for 1 cycle; waitrequest low 2 cycles after request.
- Read addr 0x03, slave returns 0x3C after 4 wait states -> avs_readdata=0x3C, waitrequest low exactly 1 cycle, 7 cycles total.
- DATA_W=32 write with byteenable 4'b0110 -> wbm_sel_o=4'b0110; write does not change avs_readdata.
- Timeout enabled, TIMEOUT_CYC=8, slave never acks -> cyc drops after 8 BUS cycles, readdata=0xFF, timeout_o single pulse, timeout_cnt_o=1; 300 aborts -> timeout_cnt_o=255.
- Ack asserted on the expiry cycle -> normal completion, timeout_o stays 0.
- rsi_reset asserted during BUS -> next edge cyc/stb=0, waitrequest=1; a late ack is ignored; the next request completes normally.
